// File: rtl/debounce_sync.sv
// Debouncer: SYNC_STAGES-flop synchronizer followed by a stability-counter filter.
// Optional rejected-transition counter enabled by DEBOUNCE_GLITCH_CNT_EN.
module debounce_sync #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 1000,
  parameter int   CNT_W         = 16,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_in,
  output logic       d_out,
  output logic       busy,
  output logic [7:0] glitch_cnt
);

  typedef enum logic {STABLE, VERIFY} state_t;

  localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   s;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  // Synchronizer stage boundary: plain shift chain, nothing between flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], d_in};
    end
  end

  assign s = sync_p[SYNC_STAGES-1];

  // Filter stage boundary: bounce-back is tested before the terminal count,
  // so a sample equal to d_out always aborts without updating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= STABLE;
      cnt   <= '0;
      d_out <= RESET_LEVEL;
      busy  <= 1'b0;
    end else begin
      case (state)
        STABLE: begin
          if (s != d_out) begin
            state <= VERIFY;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        VERIFY: begin
          if (s == d_out) begin
            state <= STABLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == TERM) begin
            d_out <= s;
            state <= STABLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic       bounce;
  logic [7:0] glitch_q;

  assign bounce = (state == VERIFY) && (s == d_out);

  // Saturating count of VERIFY exits caused by the input bouncing back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_q <= 8'd0;
    end else if (bounce && (glitch_q != 8'hFF)) begin
      glitch_q <= glitch_q + 8'd1;
    end
  end

  assign glitch_cnt = glitch_q;
`else
  assign glitch_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: directed scenarios plus random input
// segments, compared against a run-length reference model.
module tb_debounce_sync;

  localparam int   SS = 2;
  localparam int   SC = 4;
  localparam logic RL = 1'b0;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_in;
  logic       d_out;
  logic       busy;
  logic [7:0] glitch_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  debounce_sync #(
    .SYNC_STAGES  (SS),
    .STABLE_CYCLES(SC),
    .CNT_W        (16),
    .RESET_LEVEL  (RL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .d_in      (d_in),
    .d_out     (d_out),
    .busy      (busy),
    .glitch_cnt(glitch_cnt)
  );

  // Reference model: the filter input is d_in delayed by SS samples; d_out
  // flips once SC+1 consecutive samples disagree with it, and any run that
  // ends early by agreeing again counts as a glitch.
  logic q[$];
  logic m_dout;
  int   run;
  int   m_glitch;

  function automatic logic [7:0] exp_glitch();
`ifdef DEBOUNCE_GLITCH_CNT_EN
    return 8'(m_glitch);
`else
    return 8'd0;
`endif
  endfunction

  task automatic model_reset();
    q = {};
    for (int i = 0; i < SS; i++) q.push_back(RL);
    m_dout   = RL;
    run      = 0;
    m_glitch = 0;
  endtask

  task automatic model_edge();
    logic smp;
    if (rst) begin
      model_reset();
    end else begin
      smp = q.pop_front();
      q.push_back(d_in);
      if (smp != m_dout) begin
        run++;
        if (run == SC + 1) begin
          m_dout = smp;
          run    = 0;
        end
      end else if (run > 0) begin
        run = 0;
        if (m_glitch < 255) m_glitch++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".d_out"}, {7'd0, d_out}, {7'd0, m_dout});
    check({tag, ".busy"}, {7'd0, busy}, {7'd0, (run > 0)});
    check({tag, ".glitch"}, glitch_cnt, exp_glitch());
  endtask

  // One clock: advance model at the edge, compare at the following falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    int   trans;
    logic prev;

    rst  = 1'b1;
    d_in = 1'b0;
    model_reset();
    #2;
    check_all("rst_init");

    // Reset held while d_in toggles: outputs pinned, both between and after edges.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      d_in = ~d_in;
      #2;
      check_all("rst_hold_pre");
      #5;
      check_all("rst_hold_post");
    end
    @(negedge clk);
    d_in = 1'b0;
    rst  = 1'b0;
    for (int i = 0; i < 3; i++) step("idle");
    check("idle.busy_const", {7'd0, busy}, 8'd0);

    // Clean rise.
    d_in = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      step("rise");
      if (k == 2) check("rise.busy_e2", {7'd0, busy}, 8'd1);
      if (k == 5) check("rise.dout_e5", {7'd0, d_out}, 8'd0);
      if (k == 6) begin
        check("rise.dout_e6", {7'd0, d_out}, 8'd1);
        check("rise.busy_e6", {7'd0, busy}, 8'd0);
      end
    end
    for (int i = 0; i < 5; i++) step("rise_hold");
    check("rise_hold.dout", {7'd0, d_out}, 8'd1);

    // Clean fall, counting d_out transitions.
    trans = 0;
    prev  = d_out;
    d_in  = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      step("fall");
      if (d_out != prev) trans++;
      prev = d_out;
      if (k == 5) check("fall.dout_e5", {7'd0, d_out}, 8'd1);
      if (k == 6) check("fall.dout_e6", {7'd0, d_out}, 8'd0);
    end
    check("fall.transitions", 8'(trans), 8'd1);

    // Bounce rejection: 2-cycle pulse.
    d_in = 1'b1;
    step("bounce_e0");
    step("bounce_e1");
    d_in = 1'b0;
    step("bounce_e2");
    check("bounce.busy_e2", {7'd0, busy}, 8'd1);
    step("bounce_e3");
    check("bounce.busy_e3", {7'd0, busy}, 8'd1);
    step("bounce_e4");
    check("bounce.busy_e4", {7'd0, busy}, 8'd0);
    for (int i = 0; i < 6; i++) step("bounce_tail");
    check("bounce.dout", {7'd0, d_out}, 8'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("bounce.glitch", glitch_cnt, 8'd1);
`else
    check("bounce.glitch", glitch_cnt, 8'd0);
`endif

    // Reset mid-verify, released before edge 8 with d_in still high.
    d_in = 1'b1;
    for (int k = 0; k <= 4; k++) step("midrst");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("midrst.assert");
    check("midrst.busy_now", {7'd0, busy}, 8'd0);
    for (int k = 5; k <= 7; k++) @(negedge clk);
    rst = 1'b0;
    for (int k = 8; k <= 14; k++) begin
      step("midrst_refill");
      if (k == 13) check("midrst.dout_e13", {7'd0, d_out}, 8'd0);
      if (k == 14) check("midrst.dout_e14", {7'd0, d_out}, 8'd1);
    end

    // Asynchronous reset with d_out high: drops before any clock edge.
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async.dout", {7'd0, d_out}, 8'd0);
    check_all("async");
    @(negedge clk);
    d_in = 1'b0;
    rst  = 1'b0;
    for (int i = 0; i < 4; i++) step("async_tail");

    // Saturation: 300 two-cycle pulses.
    for (int p = 0; p < 300; p++) begin
      d_in = 1'b1;
      step("sat_hi");
      step("sat_hi");
      d_in = 1'b0;
      for (int i = 0; i < 4; i++) step("sat_lo");
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("sat.glitch", glitch_cnt, 8'd255);
`else
    check("sat.glitch", glitch_cnt, 8'd0);
`endif
    check("sat.dout", {7'd0, d_out}, 8'd0);

    // Random segments with occasional asynchronous reset pulses.
    for (int seg = 0; seg < 400; seg++) begin
      int hold;
      d_in = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 8);
      for (int i = 0; i < hold; i++) step("rand");
      if ($urandom_range(0, 49) == 0) begin
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rand_rst");
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
